// File: rtl/fifo_drain_proc.sv
// fifo_drain_proc: pops words from a registered-read FIFO, holds each for PROC_CYCLES, then accumulates and pulses done.
// Optional parity check on the popped word is enabled with `define FIFO_DRAIN_PARITY_CHK_EN.
module fifo_drain_proc #(
    parameter int DATA_W      = 8,
    parameter int ACC_W       = 16,
    parameter int PROC_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
`ifdef FIFO_DRAIN_PARITY_CHK_EN
    input  logic              fifo_rd_par,
    output logic              parity_err,
`endif
    output logic              fifo_rd_en,
    input  logic              acc_clr,
    output logic [ACC_W-1:0]  result_out,
    output logic [7:0]        word_count,
    output logic              busy,
    output logic              processing_done
);
    typedef enum logic [2:0] {IDLE, READ, CAPTURE, PROCESS, DONE} state_t;
    state_t state, next_state;
    logic [DATA_W-1:0] word_reg;
    logic [7:0]        cnt;
    logic [ACC_W-1:0]  acc_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state == IDLE    ? (fifo_empty ? IDLE : READ) :
                     state == READ    ? CAPTURE :
                     state == CAPTURE ? PROCESS :
                     state == PROCESS ? (cnt == 8'd0 ? DONE : PROCESS) : IDLE;
    end

    always_comb begin
        fifo_rd_en      = state == READ;
        busy            = state != IDLE;
        processing_done = state == DONE;
    end

    // result_out doubles as the accumulator; a clear in DONE restarts it from the current word
    assign acc_next = (acc_clr ? '0 : result_out) + ACC_W'(word_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_reg   <= '0;
            cnt        <= '0;
            result_out <= '0;
            word_count <= '0;
        end else begin
            if (state == CAPTURE) word_reg <= fifo_rd_data;
            if (state == CAPTURE) cnt <= 8'(PROC_CYCLES - 1);
            else if (state == PROCESS) cnt <= cnt - 8'd1;
            if (state == DONE) result_out <= acc_next;
            else if (acc_clr) result_out <= '0;
            if (state == DONE) word_count <= word_count + 8'd1;
        end
    end

`ifdef FIFO_DRAIN_PARITY_CHK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) parity_err <= 1'b0;
        else      parity_err <= (parity_err & ~acc_clr) | (state == CAPTURE && (^{fifo_rd_data, fifo_rd_par}));
    end
`endif
endmodule
